// File: rtl/readout.sv
// readout: streams every byte of the full acquisition RAM (address 0 to last) to the host
// transmitter once per grant. Define READOUT_CKSUM_EN to append a zero-sum checksum byte.
module readout #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              grant_rd,
    output logic              done_rd,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned       LAT_W     = 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_READ  = 6'b000010,
        S_LAT   = 6'b000100,
        S_SEND  = 6'b001000,
        S_CKSUM = 6'b010000,
        S_DONE  = 6'b100000
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_en;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_done_rd;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic              w_xfer;

    assign w_xfer = r_tx_valid & tx_ready;

`ifdef READOUT_CKSUM_EN
    // Running sum of accepted data bytes; the trailing byte is its negation.
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_acc_next;

    assign w_acc_next = r_acc + r_tx_data;
`endif

    // rd_en is pulsed on every entry into READ, so it is high exactly for the READ cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rd_addr  <= '0;
            r_rd_en    <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_done_rd  <= 1'b0;
            r_lat_cnt  <= '0;
`ifdef READOUT_CKSUM_EN
            r_acc      <= '0;
`endif
        end else begin
            r_rd_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (grant_rd) begin
                        r_state   <= S_READ;
                        r_rd_addr <= '0;
                        r_rd_en   <= 1'b1;
`ifdef READOUT_CKSUM_EN
                        r_acc     <= '0;
`endif
                    end
                end
                S_READ: begin
                    r_state   <= S_LAT;
                    r_lat_cnt <= '0;
                end
                S_LAT: begin
                    if (r_lat_cnt == LAT_LAST) begin
                        r_tx_data  <= rd_data;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_SEND;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
`ifdef READOUT_CKSUM_EN
                        r_acc <= w_acc_next;
`endif
                        if (r_rd_addr == LAST_ADDR) begin
`ifdef READOUT_CKSUM_EN
                            r_state    <= S_CKSUM;
                            r_tx_data  <= DATA_W'(0) - w_acc_next;
                            r_tx_valid <= 1'b1;
`else
                            r_state    <= S_DONE;
                            r_tx_valid <= 1'b0;
                            r_done_rd  <= 1'b1;
`endif
                        end else begin
                            r_state    <= S_READ;
                            r_tx_valid <= 1'b0;
                            r_rd_addr  <= r_rd_addr + ADDR_W'(1);
                            r_rd_en    <= 1'b1;
                        end
                    end
                end
`ifdef READOUT_CKSUM_EN
                S_CKSUM: begin
                    if (w_xfer) begin
                        r_state    <= S_DONE;
                        r_tx_valid <= 1'b0;
                        r_done_rd  <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    if (!grant_rd) begin
                        r_state   <= S_IDLE;
                        r_done_rd <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign done_rd  = r_done_rd;
    assign rd_addr  = r_rd_addr;
    assign rd_en    = r_rd_en;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_readout.sv
// Bench for readout: a byte-queue model of the expected stream plus directed scenarios
// (full pass, backpressure, grant drop, mid-pass reset, checksum, two-cycle RAM).
module tb_readout;

    localparam int unsigned NBYTES = 1024;
`ifdef READOUT_CKSUM_EN
    localparam int unsigned CK      = 1;
    localparam logic [7:0]  T1_LAST = 8'h00;
    localparam logic [7:0]  T6_LAST = 8'h00;
`else
    localparam int unsigned CK      = 0;
    localparam logic [7:0]  T1_LAST = 8'hFF;
    localparam logic [7:0]  T6_LAST = 8'hFC;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       grant, grant2;
    logic       tx_ready, tx_ready2;
    logic       done_rd, rd_en, tx_valid;
    logic [9:0] rd_addr;
    logic [7:0] rd_data, tx_data;
    logic       done2, rd_en2, tx_valid2;
    logic [9:0] rd_addr2;
    logic [7:0] rd_data2, tx_data2;

    always #5 clk = ~clk;

    readout #(.ADDR_W(10), .DATA_W(8), .RD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .grant_rd(grant), .done_rd(done_rd),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    readout #(.ADDR_W(10), .DATA_W(8), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .grant_rd(grant2), .done_rd(done2),
        .rd_addr(rd_addr2), .rd_en(rd_en2), .rd_data(rd_data2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2)
    );

    // RAM models: one-cycle and two-cycle read latency over the same contents
    logic [7:0] mem [NBYTES];
    logic [7:0] ram_q, ram2_a, ram2_b;
    always @(posedge clk) begin
        if (rd_en) ram_q <= mem[rd_addr];
        if (rd_en2) ram2_a <= mem[rd_addr2];
        ram2_b <= ram2_a;
    end
    assign rd_data  = ram_q;
    assign rd_data2 = ram2_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];
    logic [7:0] last_byte, last_byte2, hold_data, e_byte;
    logic       hold_prev;
    int         n_sent, n_sent2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Expected stream: every RAM byte in address order, then the negated sum if enabled
    task automatic load_exp();
        int sum;
        sum = 0;
        exp_q.delete();
        exp2_q.delete();
        n_sent  = 0;
        n_sent2 = 0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            exp_q.push_back(mem[i]);
            exp2_q.push_back(mem[i]);
            sum += int'(mem[i]);
        end
`ifdef READOUT_CKSUM_EN
        exp_q.push_back(8'(0 - sum));
        exp2_q.push_back(8'(0 - sum));
`endif
    endtask

    function automatic bit probe(input int sel, input int tgt);
        case (sel)
            0:       return tx_valid;
            1:       return done_rd;
            2:       return tx_valid2;
            3:       return done2;
            default: return int'(rd_addr) == tgt;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int sel, input int tgt, input int budget,
                            output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (probe(sel, tgt)) begin
                at = cyc;
                break;
            end
        end
        n_checks++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL %s timeout actual=not_seen required=within_%0d_clocks", nm, budget);
        end
    endtask

    // Per-cycle compare of both DUTs against the queued expected stream
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev) begin
                chk("hold_valid", 32'(tx_valid), 32'(1));
                chk("hold_data", 32'(tx_data), 32'(hold_data));
            end
            if (tx_valid) chk("rd_en_while_valid", 32'(rd_en), 32'(0));
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte_count", 32'(n_sent + 1), 32'(NBYTES + CK));
                end else begin
                    e_byte = exp_q.pop_front();
                    chk($sformatf("byte_%0d", n_sent), 32'(tx_data), 32'(e_byte));
                end
                last_byte = tx_data;
                n_sent++;
            end
            hold_prev = tx_valid && !tx_ready;
            hold_data = tx_data;
            if (tx_valid2) chk("rd_en2_while_valid", 32'(rd_en2), 32'(0));
            if (tx_valid2 && tx_ready2) begin
                if (exp2_q.size() == 0) begin
                    chk("extra_byte2_count", 32'(n_sent2 + 1), 32'(NBYTES + CK));
                end else begin
                    e_byte = exp2_q.pop_front();
                    chk($sformatf("lat2_byte_%0d", n_sent2), 32'(tx_data2), 32'(e_byte));
                end
                last_byte2 = tx_data2;
                n_sent2++;
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic pulse_grant(output int c0);
        @(negedge clk);
        grant = 1'b1;
        @(posedge clk);
        #1;
        c0    = cyc;
        grant = 1'b0;
    endtask

    initial begin
        int c0, t;
        rst_n = 1'b0; grant = 1'b0; grant2 = 1'b0; tx_ready = 1'b1; tx_ready2 = 1'b1;
        hold_prev = 1'b0; n_sent = 0; n_sent2 = 0;
        for (int i = 0; i < int'(NBYTES); i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(done_rd), 32'(0));
        chk("rst_addr", 32'(rd_addr), 32'(0));
        chk("rst_rd_en", 32'(rd_en), 32'(0));
        chk("rst_tx_data", 32'(tx_data), 32'(0));
        chk("rst_tx_valid", 32'(tx_valid), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Full pass, ready always high; sampling edge of grant counted as clock 1
        load_exp();
        pulse_grant(c0);
        wait_for("t1_first_valid", 0, 0, 10, t);
        chk("t1_first_valid_clk", 32'(t - c0), 32'(2));
        chk("t1_first_byte", 32'(tx_data), 32'h00);
        wait_for("t1_done", 1, 0, 4000, t);
        chk("t1_done_clk", 32'(t - c0), 32'(3072 + CK));
        chk("t1_bytes_sent", 32'(n_sent), 32'(NBYTES + CK));
        chk("t1_last_byte", 32'(last_byte), 32'(T1_LAST));
        chk("t1_addr_at_done", 32'(rd_addr), 32'h3FF);
        @(posedge clk);
        #1;
        chk("t1_done_fall", 32'(done_rd), 32'(0));

        // Backpressure on byte 0x05 for 10 clocks
        load_exp();
        grant = 1'b1;
        wait_for("t2_addr5", 4, 5, 100, t);
        tx_ready = 1'b0;
        wait_for("t2_valid", 0, 0, 10, t);
        for (int i = 0; i < 10; i++) begin
            chk("t2_valid_held", 32'(tx_valid), 32'(1));
            chk("t2_data_held", 32'(tx_data), 32'h05);
            chk("t2_no_rd_en", 32'(rd_en), 32'(0));
            chk("t2_addr_held", 32'(rd_addr), 32'h005);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        wait_for("t2_done", 1, 0, 4000, t);
        chk("t2_bytes_sent", 32'(n_sent), 32'(NBYTES + CK));
        grant = 1'b0;
        @(posedge clk);
        #1;
        chk("t2_done_fall", 32'(done_rd), 32'(0));

        // Grant dropped at byte 100: pass still completes
        load_exp();
        grant = 1'b1;
        wait_for("t3_addr100", 4, 100, 1000, t);
        grant = 1'b0;
        wait_for("t3_done", 1, 0, 4000, t);
        chk("t3_bytes_sent", 32'(n_sent), 32'(NBYTES + CK));
        @(posedge clk);
        #1;
        chk("t3_done_fall", 32'(done_rd), 32'(0));

        // Second grant restarts at 0, then reset lands mid-pass at byte 500
        load_exp();
        grant = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_restart_addr", 32'(rd_addr), 32'h000);
        chk("t3_restart_rd_en", 32'(rd_en), 32'(1));
        wait_for("t4_addr500", 4, 500, 2000, t);
        #2;
        rst_n = 1'b0;
        grant = 1'b0;
        #1;
        chk("t4_rst_addr", 32'(rd_addr), 32'(0));
        chk("t4_rst_rd_en", 32'(rd_en), 32'(0));
        chk("t4_rst_tx_data", 32'(tx_data), 32'(0));
        chk("t4_rst_tx_valid", 32'(tx_valid), 32'(0));
        chk("t4_rst_done", 32'(done_rd), 32'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load_exp();
        pulse_grant(c0);
        chk("t4_restart_addr", 32'(rd_addr), 32'h000);
        chk("t4_restart_rd_en", 32'(rd_en), 32'(1));
        wait_for("t4_done", 1, 0, 4000, t);
        chk("t4_done_clk", 32'(t - c0), 32'(3072 + CK));
        chk("t4_bytes_sent", 32'(n_sent), 32'(NBYTES + CK));
        @(posedge clk);
        #1;

`ifdef READOUT_CKSUM_EN
        // Checksum byte: RAM[0]=3 others 0, then all ones
        for (int i = 0; i < int'(NBYTES); i++) mem[i] = 8'h00;
        mem[0] = 8'h03;
        load_exp();
        pulse_grant(c0);
        wait_for("t5a_done", 1, 0, 4000, t);
        chk("t5a_bytes_sent", 32'(n_sent), 32'(1025));
        chk("t5a_cksum", 32'(last_byte), 32'hFD);
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NBYTES); i++) mem[i] = 8'h01;
        load_exp();
        pulse_grant(c0);
        wait_for("t5b_done", 1, 0, 4000, t);
        chk("t5b_bytes_sent", 32'(n_sent), 32'(1025));
        chk("t5b_cksum", 32'(last_byte), 32'h00);
        @(posedge clk);
        #1;
`endif

        // Two-cycle RAM: four clocks per byte
        for (int i = 0; i < int'(NBYTES); i++) mem[i] = 8'(i * 7 + 3);
        load_exp();
        @(negedge clk);
        grant2 = 1'b1;
        @(posedge clk);
        #1;
        c0     = cyc;
        grant2 = 1'b0;
        wait_for("t6_first_valid", 2, 0, 10, t);
        chk("t6_first_valid_clk", 32'(t - c0), 32'(3));
        chk("t6_first_byte", 32'(tx_data2), 32'h03);
        wait_for("t6_done", 3, 0, 5000, t);
        chk("t6_done_clk", 32'(t - c0), 32'(4096 + CK));
        chk("t6_bytes_sent", 32'(n_sent2), 32'(NBYTES + CK));
        chk("t6_last_byte", 32'(last_byte2), 32'(T6_LAST));
        @(posedge clk);
        #1;
        chk("t6_done_fall", 32'(done2), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog actual=still_running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
